jtag_tap_responder: RTL and testbench

- Synthesizable JTAG TAP, the device-side responder to the simulation JTAG driver.
- Oversamples jtag_TCK/TMS/TDI/TRSTn in the system clock domain.
- Runs the IEEE 1149.1 16-state TAP FSM and implements IR, IDCODE, BYPASS and one user data register with capture/update strobes toward a debug module.
- Returns jtag_TDO_data/jtag_TDO_driven to the driver.

---
 rtl/jtag_tap_pkg.sv | 38 +++
 rtl/jtag_sync_edge.sv | 43 ++++
 rtl/jtag_tap_responder.sv | 198 +++++++++++++++++++
 tb/tb_jtag_tap_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding, DR selection and fixed
// IR patterns used by the JTAG TAP responder.
package jtag_tap_pkg;

  localparam int unsigned IDCODE_WIDTH = 32;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

  // All-ones BYPASS code, sliced down to the IR width by the user.
  localparam logic [31:0] BYPASS_ALL_ONES = 32'hFFFF_FFFF;

  // Low bits loaded into the IR shift register at Capture-IR.
  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_sync_edge.sv
// Brings the JTAG pins into the system clock domain and derives single-cycle
// TCK rise/fall strobes aligned with the synchronized TMS/TDI/TRSTn.
module jtag_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  input  logic trstn_i,
  output logic tck_rise_c,
  output logic tck_fall_c,
  output logic tms_o,
  output logic tdi_o,
  output logic trstn_o
);

  logic [2:0] tck_q;
  logic [1:0] tms_q;
  logic [1:0] tdi_q;
  logic [1:0] trstn_q;

  // TRSTn resets low so the TAP stays in reset until the pin is seen high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tck_q   <= '0;
      tms_q   <= '0;
      tdi_q   <= '0;
      trstn_q <= '0;
    end else begin
      tck_q   <= {tck_q[1:0], tck_i};
      tms_q   <= {tms_q[0], tms_i};
      tdi_q   <= {tdi_q[0], tdi_i};
      trstn_q <= {trstn_q[0], trstn_i};
    end
  end

  assign tck_rise_c = tck_q[1] & ~tck_q[2];
  assign tck_fall_c = ~tck_q[1] & tck_q[2];
  assign tms_o      = tms_q[1];
  assign tdi_o      = tdi_q[1];
  assign trstn_o    = trstn_q[1];

endmodule

// File: rtl/jtag_tap_responder.sv
// Device-side JTAG TAP: oversampled 16-state TAP FSM with IR, IDCODE, BYPASS
// and one user data register exposing capture/update strobes.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter int unsigned          IR_WIDTH     = 5,
  parameter logic [31:0]          IDCODE_VALUE = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0]  IDCODE_INSTR = IR_WIDTH'(5'h01),
  parameter logic [IR_WIDTH-1:0]  USER_INSTR   = IR_WIDTH'(5'h11),
  parameter int unsigned          DR_WIDTH     = 41
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jtag_TCK,
  input  logic                jtag_TMS,
  input  logic                jtag_TDI,
  input  logic                jtag_TRSTn,
  output logic                jtag_TDO_data,
  output logic                jtag_TDO_driven,
  input  logic [DR_WIDTH-1:0] dr_capture_data,
  output logic                dr_capture,
  output logic                dr_update_valid,
  output logic [DR_WIDTH-1:0] dr_update_data,
  output logic [3:0]          tap_state
);

  localparam logic [IR_WIDTH-1:0] BYPASS_INSTR = BYPASS_ALL_ONES[IR_WIDTH-1:0];

  logic tck_rise, tck_fall, tms_s, tdi_s, trstn_s;

  jtag_sync_edge u_sync (
    .clock      (clock),
    .reset      (reset),
    .tck_i      (jtag_TCK),
    .tms_i      (jtag_TMS),
    .tdi_i      (jtag_TDI),
    .trstn_i    (jtag_TRSTn),
    .tck_rise_c (tck_rise),
    .tck_fall_c (tck_fall),
    .tms_o      (tms_s),
    .tdi_o      (tdi_s),
    .trstn_o    (trstn_s)
  );

  tap_state_e                state_q, state_d;
  logic [IR_WIDTH-1:0]       ir_q, ir_d;
  logic [IR_WIDTH-1:0]       ir_shift_q, ir_shift_d;
  logic [IDCODE_WIDTH-1:0]   idcode_q, idcode_d;
  logic [DR_WIDTH-1:0]       user_q, user_d;
  logic                      bypass_q, bypass_d;
  logic                      tdo_q, tdo_d;
  logic                      tdo_en_q, tdo_en_d;
  logic                      capture_q, capture_d;
  logic                      update_q, update_d;
  logic [DR_WIDTH-1:0]       upd_data_q, upd_data_d;

  dr_sel_e dr_sel;
  logic    dr_lsb;

  // Data register routing from the current instruction.
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_q == BYPASS_INSTR) begin
      dr_sel = SEL_BYPASS;
    end else if (ir_q == IDCODE_INSTR) begin
      dr_sel = SEL_IDCODE;
    end else if (ir_q == USER_INSTR) begin
      dr_sel = SEL_USER;
    end
    unique case (dr_sel)
      SEL_IDCODE: dr_lsb = idcode_q[0];
      SEL_USER:   dr_lsb = user_q[0];
      default:    dr_lsb = bypass_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    idcode_d   = idcode_q;
    user_d     = user_q;
    bypass_d   = bypass_q;
    tdo_d      = tdo_q;
    tdo_en_d   = tdo_en_q;
    capture_d  = 1'b0;
    update_d   = 1'b0;
    upd_data_d = upd_data_q;

    if (!trstn_s) begin
      state_d  = TEST_LOGIC_RESET;
      ir_d     = IDCODE_INSTR;
      tdo_en_d = 1'b0;
    end else if (tck_rise) begin
      unique case (state_q)
        TEST_LOGIC_RESET: state_d = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state_d = tms_s ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:        state_d = tms_s ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       state_d = tms_s ? EXIT1_DR  : SHIFT_DR;
        SHIFT_DR:         state_d = tms_s ? EXIT1_DR  : SHIFT_DR;
        EXIT1_DR:         state_d = tms_s ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         state_d = tms_s ? EXIT2_DR  : PAUSE_DR;
        EXIT2_DR:         state_d = tms_s ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        state_d = tms_s ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:        state_d = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state_d = tms_s ? EXIT1_IR  : SHIFT_IR;
        SHIFT_IR:         state_d = tms_s ? EXIT1_IR  : SHIFT_IR;
        EXIT1_IR:         state_d = tms_s ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         state_d = tms_s ? EXIT2_IR  : PAUSE_IR;
        EXIT2_IR:         state_d = tms_s ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:        state_d = tms_s ? SELECT_DR : RUN_TEST_IDLE;
        default:          state_d = TEST_LOGIC_RESET;
      endcase

      // Register actions belong to the state being left on this rise.
      case (state_q)
        CAPTURE_IR: ir_shift_d = IR_WIDTH'(IR_CAPTURE);
        SHIFT_IR:   ir_shift_d = {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
        UPDATE_IR:  ir_d = ir_shift_q;
        CAPTURE_DR: begin
          unique case (dr_sel)
            SEL_IDCODE: idcode_d = IDCODE_VALUE;
            SEL_USER: begin
              user_d    = dr_capture_data;
              capture_d = 1'b1;
            end
            default:    bypass_d = 1'b0;
          endcase
        end
        SHIFT_DR: begin
          unique case (dr_sel)
            SEL_IDCODE: idcode_d = {tdi_s, idcode_q[IDCODE_WIDTH-1:1]};
            SEL_USER:   user_d   = {tdi_s, user_q[DR_WIDTH-1:1]};
            default:    bypass_d = tdi_s;
          endcase
        end
        UPDATE_DR: begin
          if (dr_sel == SEL_USER) begin
            update_d   = 1'b1;
            upd_data_d = user_q;
          end
        end
        default: ;
      endcase

      if (state_d == TEST_LOGIC_RESET) begin
        ir_d = IDCODE_INSTR;
      end
    end else if (tck_fall) begin
      // Launch on the falling edge so TDO is stable at the next TCK rise.
      if (state_q == SHIFT_IR) begin
        tdo_en_d = 1'b1;
        tdo_d    = ir_shift_q[0];
      end else if (state_q == SHIFT_DR) begin
        tdo_en_d = 1'b1;
        tdo_d    = dr_lsb;
      end else begin
        tdo_en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= TEST_LOGIC_RESET;
      ir_q       <= IDCODE_INSTR;
      ir_shift_q <= '0;
      idcode_q   <= '0;
      user_q     <= '0;
      bypass_q   <= 1'b0;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
      capture_q  <= 1'b0;
      update_q   <= 1'b0;
      upd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      idcode_q   <= idcode_d;
      user_q     <= user_d;
      bypass_q   <= bypass_d;
      tdo_q      <= tdo_d;
      tdo_en_q   <= tdo_en_d;
      capture_q  <= capture_d;
      update_q   <= update_d;
      upd_data_q <= upd_data_d;
    end
  end

  assign jtag_TDO_data   = tdo_q;
  assign jtag_TDO_driven = tdo_en_q;
  assign dr_capture      = capture_q;
  assign dr_update_valid = update_q;
  assign dr_update_data  = upd_data_q;
  assign tap_state       = state_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Self-checking bench for jtag_tap_responder: directed scans plus randomized
// TAP traffic compared against a behavioural TAP model.
module tb_jtag_tap_responder;

  localparam int unsigned DR_W     = 41;
  localparam logic [31:0] IDCODE   = 32'h1000_0001;
  localparam logic [4:0]  I_IDCODE = 5'h01;
  localparam logic [4:0]  I_USER   = 5'h11;

  // IEEE 1149.1 state codes
  localparam logic [3:0] S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR  = 4'h2, S_PDR  = 4'h3;
  localparam logic [3:0] S_SELIR = 4'h4, S_UPDR  = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7;
  localparam logic [3:0] S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR  = 4'hA, S_PIR  = 4'hB;
  localparam logic [3:0] S_RTI   = 4'hC, S_UPIR  = 4'hD, S_CAPIR = 4'hE, S_TLR  = 4'hF;

  logic            clock, reset;
  logic            jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
  logic            jtag_TDO_data, jtag_TDO_driven;
  logic [DR_W-1:0] cap_data;
  logic            dr_capture, dr_update_valid;
  logic [DR_W-1:0] dr_update_data;
  logic [3:0]      tap_state;

  jtag_tap_responder dut (
    .clock           (clock),
    .reset           (reset),
    .jtag_TCK        (jtag_TCK),
    .jtag_TMS        (jtag_TMS),
    .jtag_TDI        (jtag_TDI),
    .jtag_TRSTn      (jtag_TRSTn),
    .jtag_TDO_data   (jtag_TDO_data),
    .jtag_TDO_driven (jtag_TDO_driven),
    .dr_capture_data (cap_data),
    .dr_capture      (dr_capture),
    .dr_update_valid (dr_update_valid),
    .dr_update_data  (dr_update_data),
    .tap_state       (tap_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Strobe activity: cycles each strobe is seen high.
  int mon_caps = 0;
  int mon_upds = 0;
  always @(negedge clock) begin
    if (dr_capture === 1'b1) mon_caps++;
    if (dr_update_valid === 1'b1) mon_upds++;
  end

  // Behavioural model
  logic [3:0]      nxt0 [16];
  logic [3:0]      nxt1 [16];
  logic [3:0]      m_state;
  logic [4:0]      m_ir, m_irsh;
  logic [63:0]     m_dr;
  int              m_len;
  logic [DR_W-1:0] m_upd;
  int              m_caps, m_upds;

  function automatic logic is_shift(input logic [3:0] s);
    return (s == S_SHIR) || (s == S_SHDR);
  endfunction

  task automatic model_reset();
    m_state = S_TLR;
    m_ir    = I_IDCODE;
    m_irsh  = '0;
    m_dr    = '0;
    m_len   = 1;
    m_upd   = '0;
  endtask

  task automatic model_rise(input logic tms, input logic tdi);
    logic [3:0] ns;
    ns = tms ? nxt1[m_state] : nxt0[m_state];
    case (m_state)
      S_CAPIR: m_irsh = 5'b00001;
      S_SHIR:  m_irsh = {tdi, m_irsh[4:1]};
      S_UPIR:  m_ir = m_irsh;
      S_CAPDR: begin
        if (m_ir == I_IDCODE) begin
          m_dr = 64'(IDCODE); m_len = 32;
        end else if (m_ir == I_USER) begin
          m_dr = 64'(cap_data); m_len = DR_W; m_caps++;
        end else begin
          m_dr = '0; m_len = 1;
        end
      end
      S_SHDR: begin
        m_dr = m_dr >> 1;
        m_dr[m_len-1] = tdi;
      end
      S_UPDR: begin
        if (m_ir == I_USER) begin
          m_upd = m_dr[DR_W-1:0]; m_upds++;
        end
      end
      default: ;
    endcase
    m_state = ns;
    if (ns == S_TLR) m_ir = I_IDCODE;
  endtask

  // One full TCK period; TDO is sampled just before the rising edge.
  task automatic tck(input logic tms, input logic tdi, output logic tdo_s);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    repeat (3) @(negedge clock);
    check("tdo_driven", 64'(jtag_TDO_driven), 64'(is_shift(m_state)));
    if (is_shift(m_state))
      check("tdo_data", 64'(jtag_TDO_data), 64'((m_state == S_SHIR) ? m_irsh[0] : m_dr[0]));
    tdo_s = jtag_TDO_data;
    jtag_TCK = 1'b1;
    model_rise(tms, tdi);
    repeat (5) @(negedge clock);
    jtag_TCK = 1'b0;
    repeat (5) @(negedge clock);
    check("tap_state", 64'(tap_state), 64'(m_state));
    check("dr_update_data", 64'(dr_update_data), 64'(m_upd));
  endtask

  task automatic goto_rti();
    logic b;
    repeat (5) tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
  endtask

  task automatic ir_scan(input logic [4:0] code, output logic [4:0] dout);
    logic b;
    tck(1'b1, 1'b0, b);
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) begin
      tck(i == 4, code[i], b);
      dout[i] = b;
    end
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
  endtask

  task automatic dr_scan(input int len, input logic [63:0] din, input int pause_at,
                         output logic [63:0] dout);
    logic b;
    dout = '0;
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b0, b);
    for (int i = 0; i < len; i++) begin
      tck((i == len - 1) || (i == pause_at), din[i], b);
      dout[i] = b;
      if (i == pause_at && i != len - 1) begin
        repeat (10) tck(1'b0, 1'b0, b);
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
      end
    end
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  o5;
    logic [63:0] o64;
    logic        b;
    int          caps0, upds0, len, pause;
    logic [4:0]  code;

    nxt0[S_TLR] = S_RTI;     nxt1[S_TLR] = S_TLR;
    nxt0[S_RTI] = S_RTI;     nxt1[S_RTI] = S_SELDR;
    nxt0[S_SELDR] = S_CAPDR; nxt1[S_SELDR] = S_SELIR;
    nxt0[S_CAPDR] = S_SHDR;  nxt1[S_CAPDR] = S_EX1DR;
    nxt0[S_SHDR] = S_SHDR;   nxt1[S_SHDR] = S_EX1DR;
    nxt0[S_EX1DR] = S_PDR;   nxt1[S_EX1DR] = S_UPDR;
    nxt0[S_PDR] = S_PDR;     nxt1[S_PDR] = S_EX2DR;
    nxt0[S_EX2DR] = S_SHDR;  nxt1[S_EX2DR] = S_UPDR;
    nxt0[S_UPDR] = S_RTI;    nxt1[S_UPDR] = S_SELDR;
    nxt0[S_SELIR] = S_CAPIR; nxt1[S_SELIR] = S_TLR;
    nxt0[S_CAPIR] = S_SHIR;  nxt1[S_CAPIR] = S_EX1IR;
    nxt0[S_SHIR] = S_SHIR;   nxt1[S_SHIR] = S_EX1IR;
    nxt0[S_EX1IR] = S_PIR;   nxt1[S_EX1IR] = S_UPIR;
    nxt0[S_PIR] = S_PIR;     nxt1[S_PIR] = S_EX2IR;
    nxt0[S_EX2IR] = S_SHIR;  nxt1[S_EX2IR] = S_UPIR;
    nxt0[S_UPIR] = S_RTI;    nxt1[S_UPIR] = S_SELDR;

    reset = 1'b0; jtag_TCK = 1'b0; jtag_TMS = 1'b1; jtag_TDI = 1'b0; jtag_TRSTn = 1'b1;
    cap_data = '0; m_caps = 0; m_upds = 0;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_tap_state", 64'(tap_state), 64'(S_TLR));
    check("rst_tdo_driven", 64'(jtag_TDO_driven), 64'd0);
    check("rst_tdo_data", 64'(jtag_TDO_data), 64'd0);
    check("rst_dr_capture", 64'(dr_capture), 64'd0);
    check("rst_dr_update_valid", 64'(dr_update_valid), 64'd0);
    check("rst_dr_update_data", 64'(dr_update_data), 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // IDCODE read after five TMS=1 clocks
    goto_rti();
    dr_scan(32, 64'(32'hDEAD_BEEF), -1, o64);
    check("idcode_scan", 64'(o64[31:0]), 64'(IDCODE));

    // BYPASS: capture pattern then one-TCK delay
    ir_scan(5'h1f, o5);
    check("ir_capture_pattern", 64'(o5), 64'(5'b00001));
    dr_scan(5, 64'(5'b01101), -1, o64);
    check("bypass_delay", 64'(o64[4:0]), 64'(5'b11010));

    // USER register capture/update
    cap_data = 41'h155_5555_5555;
    ir_scan(I_USER, o5);
    caps0 = mon_caps; upds0 = mon_upds;
    dr_scan(DR_W, 64'(41'h0AB_CDEF_0123), -1, o64);
    check("user_capture_out", 64'(o64[DR_W-1:0]), 64'(41'h155_5555_5555));
    check("user_update_data", 64'(dr_update_data), 64'(41'h0AB_CDEF_0123));
    check("user_capture_pulse", 64'(mon_caps - caps0), 64'd1);
    check("user_update_pulse", 64'(mon_upds - upds0), 64'd1);

    // TRSTn mid Shift-DR (USER), coincident with a TMS=0 rise
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b0, b);
    repeat (4) tck(1'b0, 1'b1, b);
    upds0 = mon_upds;
    jtag_TMS = 1'b0; jtag_TRSTn = 1'b0; jtag_TCK = 1'b1;
    repeat (3) @(negedge clock);
    check("trst_tap_state", 64'(tap_state), 64'(S_TLR));
    check("trst_tdo_driven", 64'(jtag_TDO_driven), 64'd0);
    jtag_TCK = 1'b0;
    repeat (5) @(negedge clock);
    jtag_TRSTn = 1'b1;
    repeat (5) @(negedge clock);
    m_state = S_TLR; m_ir = I_IDCODE;
    check("trst_no_update", 64'(mon_upds - upds0), 64'd0);
    check("trst_tap_state_hold", 64'(tap_state), 64'(S_TLR));
    tck(1'b0, 1'b0, b);
    dr_scan(32, '0, -1, o64);
    check("trst_idcode_scan", 64'(o64[31:0]), 64'(IDCODE));

    // Async reset mid Shift-IR
    tck(1'b1, 1'b0, b);
    tck(1'b1, 1'b0, b);
    tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b0, b);
    tck(1'b0, 1'b1, b);
    tck(1'b0, 1'b1, b);
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_tap_state", 64'(tap_state), 64'(S_TLR));
    check("arst_tdo_driven", 64'(jtag_TDO_driven), 64'd0);
    check("arst_tdo_data", 64'(jtag_TDO_data), 64'd0);
    check("arst_dr_update_data", 64'(dr_update_data), 64'd0);
    check("arst_dr_strobes", 64'({dr_capture, dr_update_valid}), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tck(1'b0, 1'b0, b);
    dr_scan(32, 64'(32'h1234_5678), -1, o64);
    check("arst_idcode_scan", 64'(o64[31:0]), 64'(IDCODE));

    // Pause-DR mid IDCODE shift, resume without recapture
    dr_scan(32, 64'(32'hFFFF_FFFF), 16, o64);
    check("pause_idcode_scan", 64'(o64[31:0]), 64'(IDCODE));

    // Randomized traffic against the model
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 12)); k++)
          tck(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b);
        goto_rti();
      end
      case ($urandom_range(0, 3))
        0:       code = I_IDCODE;
        1:       code = I_USER;
        2:       code = 5'h1f;
        default: code = 5'($urandom());
      endcase
      ir_scan(code, o5);
      check("rand_ir_capture", 64'(o5), 64'(5'b00001));
      cap_data = DR_W'({$urandom(), $urandom()});
      len = int'($urandom_range(1, 45));
      pause = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 44)) % len : -1;
      dr_scan(len, {$urandom(), $urandom()}, pause, o64);
      check("rand_capture_count", 64'(mon_caps), 64'(m_caps));
      check("rand_update_count", 64'(mon_upds), 64'(m_upds));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
